// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic cells.
// Holds the serial FSM state encoding and the bit-counter width helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must be able to hold 0..width, hence width+1 distinct values.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
// Shared per-bit cell of the serial subtractor.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Optional add mode (Mode port) when SERIAL_SUB_ADD_MODE_EN is defined.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             Mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output state_t           state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; the source holds its data until that edge, and valid/ready
    // are decoded from state so neither depends combinationally on the other.

    localparam int                CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] sa, sb, res, res_shifted;
    logic [CNT_W-1:0] cnt;
    logic             br, bout_q;
    logic             cell_d, cell_bout, br_next;
    logic             accept, last_bit;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last_bit  = (cnt == LAST);
    assign D         = res;
    assign Bout      = bout_q;
    assign state_dbg = state;

    full_subtractor u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_bout)
    );

`ifdef SERIAL_SUB_ADD_MODE_EN
    logic mode_q;
    // Sum bit equals the difference bit; only the carry/borrow differs.
    assign br_next = mode_q ? ((sa[0] & sb[0]) | (sa[0] & br) | (sb[0] & br))
                            : cell_bout;
`else
    assign br_next = cell_bout;
`endif

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shifted = cell_d;
        end else begin : g_res_wn
            assign res_shifted = {cell_d, res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            mode_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sa  <= A;
                        sb  <= B;
                        br  <= 1'b0;
                        cnt <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                        mode_q <= Mode;
`endif
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_next;
                    res <= res_shifted;
                    cnt <= cnt + 1'b1;
                    if (last_bit) bout_q <= br_next;
                end
                default: ;
            endcase
        end
    end

endmodule
